// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - stack pointer controller and initiator for a 2R/1W stack memory
// Define STACK_CTRL_OVERFLOW_TRAP_EN to squash ops that violate their depth requirement.
module stack_ctrl #(
  parameter int WIDTH = 5,
  parameter int SIZE  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [15:0]      din,
  output logic [15:0]      tos,
  output logic [15:0]      nos,
  output logic [WIDTH:0]   depth,
  output logic             empty,
  output logic             full,
  output logic             err,
  input  logic             err_clr,
  output logic [WIDTH-1:0] mem_dout_addr0,
  input  logic [15:0]      mem_dout0,
  output logic [WIDTH-1:0] mem_dout_addr1,
  input  logic [15:0]      mem_dout1,
  output logic             we,
  output logic [WIDTH-1:0] mem_din_addr,
  output logic [15:0]      mem_din
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SWAP2 = 1'b1} state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_REPL  = 3'd3;
  localparam logic [2:0] OP_BINOP = 3'd4;
  localparam logic [2:0] OP_DUP   = 3'd5;
  localparam logic [2:0] OP_SWAP  = 3'd6;
  localparam logic [2:0] OP_DROP2 = 3'd7;

  localparam logic [WIDTH:0] LP_FULL = (WIDTH+1)'(SIZE);
  localparam logic [WIDTH:0] LP_ONE  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] LP_TWO  = (WIDTH+1)'(2);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [WIDTH-1:0]        r_sp;
  logic [WIDTH-1:0]        w_sp_m1;
  logic [WIDTH-1:0]        w_sp_m2;
  logic [WIDTH-1:0]        w_sp_nxt;
  logic [WIDTH:0]          r_depth;
  logic [WIDTH:0]          w_depth_nxt;
  logic signed [WIDTH+2:0] w_depth_sum;
  logic                    r_err;
  logic [15:0]             r_swap_tmp;
  logic                    w_accept;
  logic                    w_bad;
  logic                    w_we;
  logic                    w_latch;
  logic [WIDTH-1:0]        w_waddr;
  logic [15:0]             w_wdata;
  logic signed [2:0]       w_delta;

  assign w_sp_m1  = r_sp - WIDTH'(1);
  assign w_sp_m2  = r_sp - WIDTH'(2);
  // Reset gating lives only on the outputs so rst_n never feeds flop data paths.
  assign w_accept = op_valid && (r_state == ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = r_sp;
    w_wdata     = din;
    w_delta     = 3'sd0;
    w_bad       = 1'b0;
    w_latch     = 1'b0;
    if (r_state == ST_SWAP2) begin
      w_we        = 1'b1;
      w_waddr     = w_sp_m2;
      w_wdata     = r_swap_tmp;
      w_state_nxt = ST_IDLE;
    end else if (w_accept) begin
      case (op)
        OP_PUSH: begin
          w_bad   = (r_depth == LP_FULL);
          w_we    = 1'b1;
          w_delta = 3'sd1;
        end
        OP_POP: begin
          w_bad   = (r_depth < LP_ONE);
          w_delta = -3'sd1;
        end
        OP_REPL: begin
          w_bad   = (r_depth < LP_ONE);
          w_we    = 1'b1;
          w_waddr = w_sp_m1;
        end
        OP_BINOP: begin
          w_bad   = (r_depth < LP_TWO);
          w_we    = 1'b1;
          w_waddr = w_sp_m2;
          w_delta = -3'sd1;
        end
        OP_DUP: begin
          w_bad   = (r_depth < LP_ONE) || (r_depth == LP_FULL);
          w_we    = 1'b1;
          w_wdata = mem_dout0;
          w_delta = 3'sd1;
        end
        OP_SWAP: begin
          w_bad       = (r_depth < LP_TWO);
          w_we        = 1'b1;
          w_waddr     = w_sp_m1;
          w_wdata     = mem_dout1;
          w_latch     = 1'b1;
          w_state_nxt = ST_SWAP2;
        end
        OP_DROP2: begin
          w_bad   = (r_depth < LP_TWO);
          w_delta = -3'sd2;
        end
        default: w_delta = 3'sd0;
      endcase
`ifdef STACK_CTRL_OVERFLOW_TRAP_EN
      if (w_bad) begin
        w_we        = 1'b0;
        w_delta     = 3'sd0;
        w_latch     = 1'b0;
        w_state_nxt = ST_IDLE;
      end
`endif
    end
  end

  // Pointer wraps modulo SIZE; depth saturates to 0..SIZE.
  assign w_sp_nxt    = r_sp + WIDTH'(w_delta);
  assign w_depth_sum = $signed({2'b00, r_depth}) + (WIDTH+3)'(w_delta);

  always_comb begin
    w_depth_nxt = w_depth_sum[WIDTH:0];
    if (w_depth_sum[WIDTH+2]) begin
      w_depth_nxt = '0;
    end else if (w_depth_sum > $signed({2'b00, LP_FULL})) begin
      w_depth_nxt = LP_FULL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sp       <= '0;
      r_depth    <= '0;
      r_err      <= 1'b0;
      r_swap_tmp <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sp    <= w_sp_nxt;
      r_depth <= w_depth_nxt;
      if (w_latch) begin
        r_swap_tmp <= mem_dout0;
      end
      if (w_accept && w_bad) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign op_ready       = rst_n && (r_state == ST_IDLE);
  assign we             = rst_n && w_we;
  assign mem_din_addr   = w_waddr;
  assign mem_din        = w_wdata;
  assign mem_dout_addr0 = w_sp_m1;
  assign mem_dout_addr1 = w_sp_m2;
  assign tos            = mem_dout0;
  assign nos            = mem_dout1;
  assign depth          = r_depth;
  assign empty          = (r_depth == '0);
  assign full           = (r_depth == LP_FULL);
  assign err            = r_err;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed self-checking bench for stack_ctrl with a behavioural stack model
module tb_stack_ctrl;
  localparam int WIDTH = 5;
  localparam int SIZE  = 32;
  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3;
  localparam logic [2:0] BINOP = 3'd4, DUP = 3'd5, SWAP = 3'd6, DROP2 = 3'd7;
`ifdef STACK_CTRL_OVERFLOW_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic             clk, rst_n, op_valid, op_ready, err_clr;
  logic [2:0]       op;
  logic [15:0]      din, tos, nos, mem_dout0, mem_dout1, mem_din;
  logic [WIDTH:0]   depth;
  logic             empty, full, err, we;
  logic [WIDTH-1:0] mem_dout_addr0, mem_dout_addr1, mem_din_addr;

  stack_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op(op), .din(din),
    .tos(tos), .nos(nos), .depth(depth), .empty(empty), .full(full), .err(err), .err_clr(err_clr),
    .mem_dout_addr0(mem_dout_addr0), .mem_dout0(mem_dout0),
    .mem_dout_addr1(mem_dout_addr1), .mem_dout1(mem_dout1),
    .we(we), .mem_din_addr(mem_din_addr), .mem_din(mem_din)
  );

  logic [15:0] mem [SIZE];
  assign mem_dout0 = mem[mem_dout_addr0];
  assign mem_dout1 = mem[mem_dout_addr1];
  always @(posedge clk) if (we) mem[mem_din_addr] <= mem_din;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: pointer, depth, sticky error and expected memory image.
  int          m_sp, m_depth;
  bit          m_err, m_busy;
  logic [15:0] m_mem [SIZE];
  logic [15:0] m_tmp;

  function automatic int idx(input int x);
    return ((x % SIZE) + SIZE) % SIZE;
  endfunction

  function automatic bit is_bad(input logic [2:0] o);
    case (o)
      PUSH:               return m_depth == SIZE;
      POP, REPL:          return m_depth < 1;
      BINOP, SWAP, DROP2: return m_depth < 2;
      DUP:                return (m_depth < 1) || (m_depth == SIZE);
      default:            return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sp = 0; m_depth = 0; m_err = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_apply(input logic [2:0] o, input logic [15:0] d, input logic clr);
    bit bad;
    int delta;
    bad   = is_bad(o);
    delta = 0;
    if (bad) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (!(TRAP && bad)) begin
      case (o)
        PUSH:  begin m_mem[idx(m_sp)] = d; delta = 1; end
        POP:   delta = -1;
        REPL:  m_mem[idx(m_sp-1)] = d;
        BINOP: begin m_mem[idx(m_sp-2)] = d; delta = -1; end
        DUP:   begin m_mem[idx(m_sp)] = m_mem[idx(m_sp-1)]; delta = 1; end
        SWAP:  begin
          m_tmp = m_mem[idx(m_sp-1)];
          m_mem[idx(m_sp-1)] = m_mem[idx(m_sp-2)];
          m_busy = 1'b1;
        end
        DROP2: delta = -2;
        default: delta = 0;
      endcase
      m_sp    = idx(m_sp + delta);
      m_depth = m_depth + delta;
      if (m_depth < 0) m_depth = 0;
      if (m_depth > SIZE) m_depth = SIZE;
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      check("cmp_op_ready", op_ready, rst_n && !m_busy);
      check("cmp_depth", depth, m_depth);
      check("cmp_empty", empty, m_depth == 0);
      check("cmp_full", full, m_depth == SIZE);
      check("cmp_err", err, m_err);
      check("cmp_addr0", mem_dout_addr0, idx(m_sp-1));
      check("cmp_tos", tos, m_mem[idx(m_sp-1)]);
      check("cmp_nos", nos, m_mem[idx(m_sp-2)]);
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [15:0] d, input logic clr);
    bit          wr;
    int          a;
    logic [15:0] wd;
    @(negedge clk);
    op_valid = 1'b1; op = o; din = d; err_clr = clr;
    #1;
    wr = (o == PUSH || o == REPL || o == BINOP || o == DUP || o == SWAP) && !(TRAP && is_bad(o));
    a  = m_sp; wd = d;
    case (o)
      REPL:    a = m_sp - 1;
      BINOP:   a = m_sp - 2;
      DUP:     wd = m_mem[idx(m_sp-1)];
      SWAP:    begin a = m_sp - 1; wd = m_mem[idx(m_sp-2)]; end
      default: a = m_sp;
    endcase
    check("op_we", we, wr);
    if (wr) begin
      check("op_waddr", mem_din_addr, idx(a));
      check("op_wdata", mem_din, wd);
    end
    @(posedge clk);
    model_apply(o, d, clr);
    if (m_busy) begin
      @(negedge clk);
      op = NOP;
      #1;
      check("swap2_ready", op_ready, 1'b0);
      check("swap2_we", we, 1'b1);
      check("swap2_waddr", mem_din_addr, idx(m_sp-2));
      check("swap2_wdata", mem_din, m_tmp);
      @(posedge clk);
      m_mem[idx(m_sp-2)] = m_tmp;
      m_busy = 1'b0;
    end
    @(negedge clk);
    op_valid = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; op_valid = 1'b0; op = NOP; din = '0; err_clr = 1'b0;
    for (int i = 0; i < SIZE; i++) begin mem[i] = '0; m_mem[i] = '0; end
    model_reset();
    #12;
    check("rst_ready", op_ready, 1'b0);
    check("rst_we", we, 1'b0);
    check("rst_depth", depth, 0);
    check("rst_empty", empty, 1'b1);
    @(negedge clk);
    rst_n = 1'b1; chk_en = 1'b1;
    #1 check("rel_ready", op_ready, 1'b1);

    do_op(PUSH, 16'h1111, 1'b0);
    do_op(PUSH, 16'h2222, 1'b0);
    check("t1_depth", depth, 2);
    check("t1_tos", tos, 16'h2222);
    check("t1_nos", nos, 16'h1111);
    check("t1_err", err, 1'b0);
    check("t1_mem0", mem[0], 16'h1111);
    check("t1_mem1", mem[1], 16'h2222);

    do_op(BINOP, 16'h3333, 1'b0);
    check("t2_depth", depth, 1);
    check("t2_tos", tos, 16'h3333);
    check("t2_mem0", mem[0], 16'h3333);
    do_op(REPL, 16'h4444, 1'b0);
    check("t2_repl_tos", tos, 16'h4444);
    check("t2_repl_depth", depth, 1);

    do_op(PUSH, 16'h000A, 1'b0);
    do_op(PUSH, 16'h000B, 1'b0);
    do_op(SWAP, 16'h0000, 1'b0);
    check("t3_tos", tos, 16'h000A);
    check("t3_nos", nos, 16'h000B);
    check("t3_depth", depth, 3);
    check("t3_ready", op_ready, 1'b1);

    for (int i = 0; i < 3; i++) do_op(POP, 16'h0, 1'b0);
    check("t4_empty", empty, 1'b1);
    do_op(POP, 16'h0, 1'b0);
    check("t4_err", err, 1'b1);
    check("t4_depth", depth, 0);
`ifdef STACK_CTRL_OVERFLOW_TRAP_EN
    check("t4_addr0", mem_dout_addr0, 31);
`else
    check("t4_addr0", mem_dout_addr0, 30);
`endif
    do_op(NOP, 16'h0, 1'b1);
    check("t4_clr", err, 1'b0);

    @(negedge clk); rst_n = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < SIZE; i++) do_op(PUSH, 16'(i), 1'b0);
    check("t5_full", full, 1'b1);
    check("t5_err0", err, 1'b0);
    check("t5_tos", tos, 16'h001F);
    do_op(PUSH, 16'hFFFF, 1'b0);
    check("t5_full2", full, 1'b1);
    check("t5_err1", err, 1'b1);
`ifdef STACK_CTRL_OVERFLOW_TRAP_EN
    check("t5_trap_tos", tos, 16'h001F);
`else
    check("t5_wrap_mem0", mem[0], 16'hFFFF);
    check("t5_wrap_tos", tos, 16'hFFFF);
`endif

    @(negedge clk);
    op_valid = 1'b1; op = SWAP; din = '0;
    @(posedge clk);
    model_apply(SWAP, 16'h0, 1'b0);
    @(negedge clk);
    op_valid = 1'b0; op = NOP;
    #1 check("t6_in_swap2", op_ready, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_ready", op_ready, 1'b0);
    check("t6_we", we, 1'b0);
    check("t6_depth", depth, 0);
    check("t6_full", full, 1'b0);
    check("t6_err", err, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_rel_ready", op_ready, 1'b1);
    check("t6_rel_depth", depth, 0);
    do_op(PUSH, 16'h5555, 1'b0);
    check("t6_push_tos", tos, 16'h5555);
    check("t6_push_depth", depth, 1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Stack-pointer controller and initiator for the CPU's 2-read/1-write stack memory (data/return stacks).
- Accepts stack operations over a valid/ready handshake and drives the memory's write port and two async read addresses.
- Presents top-of-stack (TOS) and next-of-stack (NOS) to the datapath.
- Tracks depth and flags overflow/underflow.

Parameters:
- WIDTH, 5, pointer width; must match the attached stack memory.
- SIZE, 32, number of entries; must equal 2**WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  operation request
- op_ready  out  1  controller can accept an operation
- op  in  3  opcode; encoding in Behaviour
- din  in  16  data for PUSH/REPL/BINOP
- tos  out  16  top of stack (mem[sp-1])
- nos  out  16  next of stack (mem[sp-2])
- depth  out  WIDTH+1  number of valid entries, 0..SIZE
- empty  out  1  depth==0
- full  out  1  depth==SIZE
- err  out  1  sticky over/underflow flag
- err_clr  in  1  clears err
- mem_dout_addr0  out  WIDTH  read addr 0 = sp-1
- mem_dout0  in  16  read data 0 (async)
- mem_dout_addr1  out  WIDTH  read addr 1 = sp-2
- mem_dout1  in  16  read data 1 (async)
- we  out  1  memory write enable
- mem_din_addr  out  WIDTH  write address
- mem_din  out  16  write data

Behaviour:
- Reset (async on rst_n low):
  - sp=0, depth=0, state=IDLE, err=0, swap latch=0.
  - op_ready=0 while rst_n low; op_ready=1 in the first cycle after release.
  - we=0 while in reset.
- sp indexes the next free slot and is modulo SIZE.
- tos = mem_dout0, nos = mem_dout1: combinational, valid the same cycle sp settles.
- An op is accepted on a rising clk edge with op_valid & op_ready.
- we, mem_din_addr and mem_din are combinational from the accepted op; the write lands on that same edge.
- Opcodes (min/max depth required):
  - 0 NOP: no effect.
  - 1 PUSH: write din at sp; sp+1. Requires depth<SIZE.
  - 2 POP: sp-1. Requires depth>=1.
  - 3 REPL: write din at sp-1; sp unchanged. Requires depth>=1.
  - 4 BINOP: write din at sp-2; sp-1 (pop two, push result). Requires depth>=2.
  - 5 DUP: write tos at sp; sp+1. Requires 1<=depth<SIZE.
  - 6 SWAP: two cycles; see FSM. Requires depth>=2.
  - 7 DROP2: sp-2. Requires depth>=2.
- depth changes by the same delta as sp and saturates within 0..SIZE.
- FSM states IDLE and SWAP2:
  - IDLE, accepting SWAP: write nos at sp-1, latch tos into swap_tmp, go to SWAP2.
  - SWAP2: op_ready=0; write swap_tmp at sp-2; return to IDLE.
  - SWAP total latency is 2 cycles. A new op can be accepted in the cycle after SWAP2.
- Illegal depth (op requirement not met): behaviour per the Optional Feature.
- err_clr and a new error on the same edge: err stays 1 (set wins).
- rst_n asserted during SWAP2: the second write is abandoned and the FSM returns to IDLE. Memory contents are undefined but the pointer state is clean.
- Reads are never registered; the controller adds no latency to tos/nos.

Optional Feature:
- Macro: STACK_CTRL_OVERFLOW_TRAP_EN.
- Defined:
  - An op violating its depth requirement is accepted but squashed: we=0, sp and depth unchanged.
  - err set on that edge.
- Undefined:
  - The op executes anyway; sp wraps modulo SIZE.
  - depth saturates at 0/SIZE.
  - err still set (detection always present; only the squash is optional).

Test Plan:
1. Reset then PUSH 0x1111, PUSH 0x2222 -> depth=2, tos=0x2222, nos=0x1111, we pulsed at addr 0 then 1, err=0.
2. From (1): BINOP din=0x3333 -> depth=1, tos=0x3333, write at addr 0; then REPL 0x4444 -> tos=0x4444, depth=1.
3. PUSH 0xA, PUSH 0xB, SWAP with op_valid held high -> op_ready=0 exactly one cycle; afterwards tos=0x000A, nos=0x000B, depth unchanged.
4. Empty stack, POP:
   - With STACK_CTRL_OVERFLOW_TRAP_EN: err=1, depth=0, sp=0, we=0.
   - Without it: sp=SIZE-1, depth=0, err=1.
   - Then err_clr -> err=0.
5. PUSH SIZE times (values 0..31), then PUSH 0xFFFF:
   - full=1 and err=1.
   - With the trap: tos stays 31.
   - Without the trap: mem[0] becomes 0xFFFF.
6. Issue SWAP, assert rst_n low during SWAP2 -> all outputs at reset values; after release op_ready=1, depth=0.
